// File: rtl/std_fifo_burst_reader.sv
// Drains a show-ahead FIFO in bursts of BURST_LEN words (or a partial burst after TIMEOUT idle cycles) onto a valid/ready stream.
// Latency: burst starts one cycle after the start condition; beats are combinational from the FIFO head, pop is same-cycle.
// Backpressure: i_ready=0 holds o_valid/o_data (no pop). Build with STD_FIFO_BURST_READER_STATS_EN for the burst counters.
module std_fifo_burst_reader #(
  parameter int  WIDTH     = 8,
  parameter type TYPE      = logic [WIDTH-1:0],
  parameter int  DEPTH     = 8,
  parameter int  BURST_LEN = 4,
  parameter int  TIMEOUT   = 16,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int LW        = $clog2(BURST_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_fifo_empty,
  input  logic [CW-1:0] i_fifo_word_count,
  input  TYPE           i_fifo_data,
  output logic          o_fifo_pop,
  output logic          o_valid,
  input  logic          i_ready,
  output TYPE           o_data,
  output logic          o_last,
  output logic [LW-1:0] o_len,
`ifdef STD_FIFO_BURST_READER_STATS_EN
  output logic [15:0]   o_full_bursts,
  output logic [15:0]   o_timeout_bursts,
`endif
  output logic          o_busy
);

  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int MW = (CW > LW) ? CW : LW;
  localparam logic [MW-1:0] BURST_EXT = MW'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [MW-1:0] count_ext;
  logic          full_ok;
  logic          timeout_hit;

  assign count_ext   = MW'(i_fifo_word_count);
  assign full_ok     = (count_ext >= BURST_EXT);
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_MAX) && !i_fifo_empty;

  // Show-ahead head word goes straight out; only meaningful with o_valid.
  assign o_data = i_fifo_data;
  assign o_len  = len_q;

  // Next-state, burst bookkeeping and stream/pop outputs.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    timer_d    = timer_q;
    o_valid    = 1'b0;
    o_last     = 1'b0;
    o_fifo_pop = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_ok) begin
          // A full burst always wins over a pending timeout.
          state_d = BURST;
          rem_d   = LW'(BURST_LEN);
          len_d   = LW'(BURST_LEN);
          timer_d = '0;
        end else if (timeout_hit) begin
          // Count is below BURST_LEN here, so it fits the length field.
          state_d = BURST;
          rem_d   = LW'(count_ext);
          len_d   = LW'(count_ext);
          timer_d = '0;
        end else if (i_fifo_empty) begin
          timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      BURST: begin
        timer_d = '0;
        o_busy  = 1'b1;
        // Gate with reset so no word is popped (and lost) in the reset cycle.
        o_valid = !i_fifo_empty && !i_rst;
        o_last  = o_valid && (rem_q == LW'(1));
        if (o_valid && i_ready) begin
          o_fifo_pop = 1'b1;
          rem_d      = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      timer_q <= timer_d;
    end
  end

`ifdef STD_FIFO_BURST_READER_STATS_EN
  logic        start_full, start_to;
  logic [15:0] full_cnt_q, full_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  assign start_full = (state_q == IDLE) && full_ok;
  assign start_to   = (state_q == IDLE) && !full_ok && timeout_hit;

  // Saturating per-kind burst start counters.
  always_comb begin
    full_cnt_d = full_cnt_q;
    to_cnt_d   = to_cnt_q;
    if (start_full && (full_cnt_q != 16'hFFFF)) full_cnt_d = full_cnt_q + 16'd1;
    if (start_to && (to_cnt_q != 16'hFFFF))     to_cnt_d   = to_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      full_cnt_q <= full_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign o_full_bursts    = full_cnt_q;
  assign o_timeout_bursts = to_cnt_q;
`endif

endmodule

// File: tb/tb_std_fifo_burst_reader.sv
// Directed bench for std_fifo_burst_reader with a behavioural show-ahead FIFO upstream.
// Defaults: BURST_LEN=4, DEPTH=8, TIMEOUT=16, 8-bit words.
// Each scenario task drives stimulus and checks its own expectations.
module tb_std_fifo_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ready;
  logic       push_en;
  logic [7:0] push_dat;

  // Behavioural show-ahead FIFO
  logic [7:0] mem [0:15];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;
  logic [4:0] fill;
  logic       fifo_empty;
  logic [3:0] fifo_cnt;
  logic [7:0] fifo_dat;
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == 5'd0);
  assign fifo_cnt   = fill[3:0];
  assign fifo_dat   = mem[rd_ptr[3:0]];

  logic       pop, valid, last, busy;
  logic [7:0] data;
  logic [2:0] len;
`ifdef STD_FIFO_BURST_READER_STATS_EN
  logic [15:0] full_bursts, timeout_bursts;
`endif

  std_fifo_burst_reader dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_fifo_empty      (fifo_empty),
    .i_fifo_word_count (fifo_cnt),
    .i_fifo_data       (fifo_dat),
    .o_fifo_pop        (pop),
    .o_valid           (valid),
    .i_ready           (ready),
    .o_data            (data),
    .o_last            (last),
    .o_len             (len),
`ifdef STD_FIFO_BURST_READER_STATS_EN
    .o_full_bursts     (full_bursts),
    .o_timeout_bursts  (timeout_bursts),
`endif
    .o_busy            (busy)
  );

  always @(posedge clk) begin
    if (pop) rd_ptr <= rd_ptr + 5'd1;
    if (push_en) begin
      mem[wr_ptr[3:0]] <= push_dat;
      wr_ptr <= wr_ptr + 5'd1;
    end
  end

  int errors = 0;
  int checks = 0;

  // Per-cycle samples and beat log
  logic       s_valid, s_last, s_pop, s_busy;
  logic [7:0] s_data;
  logic [2:0] s_len;
  logic [7:0] b_dat [0:63];
  logic       b_last [0:63];
  logic [2:0] b_len [0:63];
  int         b_cyc [0:63];
  int nb, pops, pop_bad, fv_cyc;
  int cyc_n = 0;

  task automatic clr_log();
    nb = 0; pops = 0; pop_bad = 0; fv_cyc = -1;
  endtask

  // One clock: sample at negedge, return 1 time unit after the next posedge.
  task automatic cyc();
    @(negedge clk);
    s_valid = valid; s_last = last; s_pop = pop; s_busy = busy;
    s_data = data; s_len = len;
    if (s_pop) pops++;
    if (s_pop !== (s_valid && ready)) pop_bad++;
    if (s_pop && !s_busy) pop_bad++;
    if (s_valid && fv_cyc < 0) fv_cyc = cyc_n;
    if (s_valid && ready && nb < 64) begin
      b_dat[nb] = s_data; b_last[nb] = s_last; b_len[nb] = s_len; b_cyc[nb] = cyc_n;
      nb++;
    end
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    push_en = 1'b1; push_dat = d;
    cyc();
    push_en = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (nb < n && k < budget) begin
      cyc();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; push_en = 1'b0; push_dat = '0;
    clr_log();
    cyc(); cyc();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", s_last); end
    checks++; if (s_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", s_pop); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    checks++; if (s_len !== 3'd0) begin errors++; $display("FAIL reset_len got=%0d exp=0", s_len); end
    rst = 1'b0;
    cyc();
    checks++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b valid=%b exp 0/0", s_busy, s_valid); end
  endtask

  task automatic test_full_burst();
    int n0;
    logic [7:0] e;
    clr_log(); ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + i));
    n0 = cyc_n;
    run_until(4, 20);
    checks++; if (nb !== 4) begin errors++; $display("FAIL full_nbeats got=%0d exp=4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      e = 8'(8'hA0 + i);
      checks++;
      if (b_dat[i] !== e || b_last[i] !== (i == 3) || b_len[i] !== 3'd4) begin
        errors++;
        $display("FAIL full_beat%0d got dat=%h last=%b len=%0d exp dat=%h last=%b len=4", i, b_dat[i], b_last[i], b_len[i], e, (i == 3));
      end
    end
    if (nb == 4) begin
      checks++; if (b_cyc[0] !== n0 + 1) begin errors++; $display("FAIL full_start_cyc got=%0d exp=%0d", b_cyc[0], n0 + 1); end
      checks++; if (b_cyc[3] !== b_cyc[0] + 3) begin errors++; $display("FAIL full_consecutive got=%0d exp=%0d", b_cyc[3], b_cyc[0] + 3); end
    end
    checks++; if (pops !== 4 || pop_bad !== 0) begin errors++; $display("FAIL full_pops got=%0d bad=%0d exp=4 bad=0", pops, pop_bad); end
    cyc();
    checks++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL full_busy_drop got busy=%b valid=%b exp 0/0", s_busy, s_valid); end
  endtask

  task automatic test_backpressure();
    int pat [0:6];
    int k;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    clr_log(); ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'hB0 + i));
    k = 0;
    while (fv_cyc < 0 && k < 10) begin cyc(); k++; end
    checks++; if (fv_cyc < 0) begin errors++; $display("FAIL bp_no_valid got none exp valid"); end
    for (int j = 0; j < 7; j++) begin
      ready = pat[j][0];
      k = nb;
      cyc();
      checks++;
      if (s_valid !== 1'b1 || s_data !== 8'(8'hB0 + k) || s_last !== (k == 3)) begin
        errors++;
        $display("FAIL bp_cycle%0d got valid=%b dat=%h last=%b exp 1/%h/%b", j, s_valid, s_data, s_last, 8'(8'hB0 + k), (k == 3));
      end
    end
    checks++; if (nb !== 4 || pops !== 4 || pop_bad !== 0) begin errors++; $display("FAIL bp_pops got beats=%0d pops=%0d bad=%0d exp 4/4/0", nb, pops, pop_bad); end
    checks++; if (nb == 4 && b_last[3] !== 1'b1) begin errors++; $display("FAIL bp_last got=%b exp=1", b_last[3]); end
    ready = 1'b1;
    cyc();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drop got=%b exp=0", s_busy); end
  endtask

  task automatic test_timeout();
    int p1;
    clr_log(); ready = 1'b1;
    push_word(8'h11);
    p1 = cyc_n;
    push_word(8'h22);
    run_until(2, 40);
    checks++; if (fv_cyc !== p1 + 17) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", fv_cyc, p1 + 17); end
    checks++; if (nb !== 2) begin errors++; $display("FAIL to_nbeats got=%0d exp=2", nb); end
    if (nb == 2) begin
      checks++; if (b_dat[0] !== 8'h11 || b_last[0] !== 1'b0 || b_len[0] !== 3'd2) begin errors++; $display("FAIL to_beat0 got %h/%b/%0d exp 11/0/2", b_dat[0], b_last[0], b_len[0]); end
      checks++; if (b_dat[1] !== 8'h22 || b_last[1] !== 1'b1 || b_len[1] !== 3'd2) begin errors++; $display("FAIL to_beat1 got %h/%b/%0d exp 22/1/2", b_dat[1], b_last[1], b_len[1]); end
    end
    cyc();
    checks++; if (s_busy !== 1'b0 || pops !== 2) begin errors++; $display("FAIL to_end got busy=%b pops=%0d exp 0/2", s_busy, pops); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] el;
    clr_log(); ready = 1'b1;
    for (int i = 0; i < 9; i++) push_word(8'(8'h30 + i));
    run_until(9, 60);
    checks++; if (nb !== 9) begin errors++; $display("FAIL b2b_nbeats got=%0d exp=9", nb); end
    for (int i = 0; i < 9 && i < nb; i++) begin
      el = (i == 8) ? 3'd1 : 3'd4;
      checks++;
      if (b_dat[i] !== 8'(8'h30 + i) || b_len[i] !== el || b_last[i] !== (i == 3 || i == 7 || i == 8)) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h/%b/%0d exp %h/%b/%0d", i, b_dat[i], b_last[i], b_len[i], 8'(8'h30 + i), (i == 3 || i == 7 || i == 8), el);
      end
    end
    if (nb == 9) begin
      checks++; if (b_cyc[4] !== b_cyc[3] + 2) begin errors++; $display("FAIL b2b_bubble got=%0d exp=%0d", b_cyc[4], b_cyc[3] + 2); end
      checks++; if (b_cyc[7] !== b_cyc[4] + 3) begin errors++; $display("FAIL b2b_burst2 got=%0d exp=%0d", b_cyc[7], b_cyc[4] + 3); end
      checks++; if (b_cyc[8] !== b_cyc[7] + 18) begin errors++; $display("FAIL b2b_tail got=%0d exp=%0d", b_cyc[8], b_cyc[7] + 18); end
    end
    checks++; if (pop_bad !== 0) begin errors++; $display("FAIL b2b_pop_bad got=%0d exp=0", pop_bad); end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    int k;
    logic [7:0] exp_d [0:3];
    exp_d = '{8'hC2, 8'hC3, 8'hD0, 8'hD1};
    clr_log(); ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
    k = 0;
    while (fv_cyc < 0 && k < 10) begin cyc(); k++; end
    ready = 1'b1;
    cyc(); cyc();
    checks++; if (nb !== 2) begin errors++; $display("FAIL rmb_pre_beats got=%0d exp=2", nb); end
    ready = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL rmb_after_rst got valid=%b busy=%b exp 0/0", s_valid, s_busy); end
    clr_log(); ready = 1'b1;
    push_word(8'hD0);
    push_word(8'hD1);
    run_until(4, 30);
    checks++; if (nb !== 4) begin errors++; $display("FAIL rmb_nbeats got=%0d exp=4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      checks++;
      if (b_dat[i] !== exp_d[i] || b_last[i] !== (i == 3) || b_len[i] !== 3'd4) begin
        errors++;
        $display("FAIL rmb_beat%0d got %h/%b/%0d exp %h/%b/4", i, b_dat[i], b_last[i], b_len[i], exp_d[i], (i == 3));
      end
    end
    cyc();
  endtask

`ifdef STD_FIFO_BURST_READER_STATS_EN
  task automatic test_stats();
    test_reset();
    ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      clr_log();
      for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
      run_until(4, 20);
      cyc();
    end
    clr_log();
    push_word(8'h77);
    run_until(1, 40);
    cyc();
    checks++; if (full_bursts !== 16'd2) begin errors++; $display("FAIL stats_full got=%0d exp=2", full_bursts); end
    checks++; if (timeout_bursts !== 16'd1) begin errors++; $display("FAIL stats_timeout got=%0d exp=1", timeout_bursts); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (full_bursts !== 16'd0 || timeout_bursts !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", full_bursts, timeout_bursts); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef STD_FIFO_BURST_READER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
